hwpe_ctrl_regfile_bist_ctrl: RTL and testbench
==============================================

HWPE_CTRL_REGFILE_BIST_CTRL -- requirements
Module: hwpe_ctrl_regfile_bist_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5: regfile address width; N = 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: word width, a multiple of 8; NUM_BYTE = DATA_WIDTH/8.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: single-cycle request to launch a test.
REQ-006 The block SHALL have the following status outputs:
- busy_o, output, 1 bit: test in progress.
- done_o, output, 1 bit: test finished (level).
- fail_o, output, 1 bit: sticky mismatch flag.
- fail_addr_o, output, ADDR_WIDTH bits: address of the first mismatch.
REQ-007 The block SHALL have the following test-port signals, driving the regfile test wrapper:
- bist_o, output, 1 bit: BIST mux select.
- csn_t_o, output, 1 bit: chip select, active-low.
- wen_t_o, output, 1 bit: write enable, active-low.
- a_t_o, output, ADDR_WIDTH bits: address.
- d_t_o, output, DATA_WIDTH bits: write data.
- be_t_o, output, NUM_BYTE bits: byte enables.
REQ-008 The block SHALL have port q_t_i, input, DATA_WIDTH bits: regfile read data, valid one cycle after a read access.

Function
REQ-009 The block SHALL run a March C- sequence; B is the data background and ~B its complement. The elements are, in order:
- M0 (up): w B
- M1 (up): r B, w ~B
- M2 (up): r ~B, w B
- M3 (down): r B, w ~B
- M4 (down): r ~B, w B
- M5 (down): r B
REQ-010 The FSM states SHALL be IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE.
REQ-011 In IDLE or DONE, start_i=1 SHALL:
- clear done_o, fail_o and fail_addr_o;
- enter M0 with address 0.
REQ-012 start_i SHALL be ignored while busy_o=1.
REQ-013 Access cadence:
- each operation SHALL occupy exactly one cycle;
- read/write elements SHALL spend 2 cycles per address (read, then write);
- there SHALL be no idle cycles between elements.
REQ-014 Address order:
- up elements SHALL count 0 to N-1;
- down elements SHALL count N-1 to 0;
- the transition to the next element SHALL occur after the terminal address, with no wrap-around access.
REQ-015 Test-port encoding:
- read: csn_t_o=0, wen_t_o=1.
- write: csn_t_o=0, wen_t_o=0.
- otherwise: csn_t_o=1, wen_t_o=1.
- be_t_o SHALL be all ones during a test.
REQ-016 Read checking:
- the expected word SHALL be pipelined one cycle;
- q_t_i SHALL be compared in the cycle after each read.
REQ-017 On a mismatch with fail_o=0:
- fail_o SHALL be set;
- fail_addr_o SHALL capture the address of that read.
REQ-018 On later mismatches, fail_o and fail_addr_o SHALL hold.
REQ-019 The test SHALL always run to completion regardless of failures.
REQ-020 After the last M5 read, FLUSH SHALL take one cycle to perform the final compare, then the FSM SHALL enter DONE.
REQ-021 Total run time SHALL be 10*N operation cycles plus 1 FLUSH cycle.
REQ-022 done_o SHALL rise exactly 10*N+2 rising edges after the edge that samples start_i.
REQ-023 busy_o SHALL be 1 from the cycle after start_i until DONE is entered.
REQ-024 bist_o SHALL equal busy_o.
REQ-025 done_o SHALL hold 1 until the next accepted start_i or rst.
REQ-026 start_i and the DONE transition occurring in the same cycle SHALL not occur, because start_i is ignored while busy.
REQ-027 When a start_i is accepted in DONE, done_o SHALL fall on the same edge on which busy_o rises.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE from any state, including mid-test.
REQ-029 After reset, the outputs SHALL take these values:
- bist_o=0, csn_t_o=1, wen_t_o=1
- a_t_o=0, d_t_o=0, be_t_o=0
- busy_o=0, done_o=0, fail_o=0, fail_addr_o=0
REQ-030 rst SHALL take priority over start_i.
REQ-031 A reset mid-test SHALL not assert done_o, and the FSM SHALL not resume afterwards.

Configuration
REQ-032 With macro HWPE_CTRL_BIST_CHECKERBOARD_EN defined, B SHALL be 0x55 repeated per byte (~B = 0xAA repeated), XORed with all ones on odd addresses (a_t_o[0]=1).
REQ-033 Without HWPE_CTRL_BIST_CHECKERBOARD_EN, B SHALL be all zeros and ~B all ones for every address.
REQ-034 Cycle timing and FSM SHALL be identical in both configurations.

Verification
REQ-035 Fault-free run: ADDR_WIDTH=2, DATA_WIDTH=32, bench regfile model with 1-cycle read latency, start_i pulse -> done_o rises exactly 42 edges later, fail_o=0, bist_o=0 afterwards.
REQ-036 Stuck-at-1, bit 0, address 2: ADDR_WIDTH=3, macro off -> fail_o=1, fail_addr_o=2, first set in the compare cycle of the M1 read of address 2.
REQ-037 Two faults: stuck-at-0 at address 6 and stuck-at-1 at address 1 -> fail_addr_o=1 (first detected in the M1 read of address 1), held through DONE.
REQ-038 Mid-test reset: rst=1 during M3 -> next cycle csn_t_o=1, bist_o=0, busy_o=0, done_o=0; a new start_i later runs the full 10*N+2 cycles.
REQ-039 Busy and restart behaviour:
- start_i pulses while busy SHALL have no effect: the same done timing and the same write/read sequence are observed.
- A start_i pulse in DONE SHALL clear done_o, fail_o and fail_addr_o and restart.
REQ-040 Checkerboard pattern: macro on, DATA_WIDTH=32 -> M0 writes d_t_o=0x55555555 at address 0 and 0xAAAAAAAA at address 1; data-line short modelled between bits 0 and 1 -> fail_o=1.

Source files
------------

// File: rtl/hwpe_ctrl_regfile_bist_ctrl.sv
// March C- BIST controller driving the test port of a regfile wrapper.
// Optional checkerboard data background: define HWPE_CTRL_BIST_CHECKERBOARD_EN.
module hwpe_ctrl_regfile_bist_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      fail_o,
  output logic [ADDR_WIDTH-1:0]     fail_addr_o,
  output logic                      bist_o,
  output logic                      csn_t_o,
  output logic                      wen_t_o,
  output logic [ADDR_WIDTH-1:0]     a_t_o,
  output logic [DATA_WIDTH-1:0]     d_t_o,
  output logic [DATA_WIDTH/8-1:0]   be_t_o,
  input  logic [DATA_WIDTH-1:0]     q_t_i
);

  localparam int NUM_BYTE = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
`ifdef HWPE_CTRL_BIST_CHECKERBOARD_EN
  localparam logic CB_EN = 1'b1;
`else
  localparam logic CB_EN = 1'b0;
`endif

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE} state_t;

  state_t                  state_q, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic                    phase_q, phase_nxt;
  logic                    op_en, op_we, op_inv;
  logic                    last_up, last_dn, accept;
  logic                    cmp_vld_q;
  logic [DATA_WIDTH-1:0]   cmp_exp_q;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q;

  // Background word: B is 0x55.. (inverted on odd addresses) with the checkerboard, else zero.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic odd, input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = ({NUM_BYTE{8'h55}} & {DATA_WIDTH{CB_EN}})
        ^ {DATA_WIDTH{odd & CB_EN}}
        ^ {DATA_WIDTH{inv}};
    return p;
  endfunction

  assign accept  = start_i && (state_q == IDLE || state_q == DONE) && !busy_o;
  assign last_up = (addr_q == ADDR_LAST);
  assign last_dn = (addr_q == {ADDR_WIDTH{1'b0}});
  assign bist_o  = busy_o;

  // Operation decode and element/address sequencing; ports lag the state by one cycle.
  always_comb begin
    op_en     = 1'b0;
    op_we     = 1'b0;
    op_inv    = 1'b0;
    state_nxt = state_q;
    addr_nxt  = addr_q;
    phase_nxt = phase_q;
    case (state_q)
      M0: begin
        op_en = 1'b1;
        op_we = 1'b1;
        if (last_up) begin
          state_nxt = M1;
          addr_nxt  = {ADDR_WIDTH{1'b0}};
        end else begin
          addr_nxt = addr_q + ADDR_WIDTH'(1);
        end
      end
      M1, M2, M3, M4: begin
        op_en     = 1'b1;
        op_we     = phase_q;
        op_inv    = (state_q == M1 || state_q == M3) ? phase_q : !phase_q;
        phase_nxt = !phase_q;
        if (!phase_q) begin
          addr_nxt = addr_q;
        end else if (state_q == M1 || state_q == M2) begin
          if (last_up) begin
            state_nxt = (state_q == M1) ? M2 : M3;
            addr_nxt  = (state_q == M1) ? {ADDR_WIDTH{1'b0}} : ADDR_LAST;
          end else begin
            addr_nxt = addr_q + ADDR_WIDTH'(1);
          end
        end else begin
          if (last_dn) begin
            state_nxt = (state_q == M3) ? M4 : M5;
            addr_nxt  = ADDR_LAST;
          end else begin
            addr_nxt = addr_q - ADDR_WIDTH'(1);
          end
        end
      end
      M5: begin
        op_en = 1'b1;
        if (last_dn) begin
          state_nxt = FLUSH;
        end else begin
          addr_nxt = addr_q - ADDR_WIDTH'(1);
        end
      end
      FLUSH:   state_nxt = DONE;
      default: state_nxt = state_q;
    endcase
  end

  // FSM, registered test port, read-compare pipeline and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      phase_q     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_addr_o <= {ADDR_WIDTH{1'b0}};
      csn_t_o     <= 1'b1;
      wen_t_o     <= 1'b1;
      a_t_o       <= {ADDR_WIDTH{1'b0}};
      d_t_o       <= {DATA_WIDTH{1'b0}};
      be_t_o      <= {NUM_BYTE{1'b0}};
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= {DATA_WIDTH{1'b0}};
      cmp_addr_q  <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (accept) begin
        state_q     <= M0;
        addr_q      <= {ADDR_WIDTH{1'b0}};
        phase_q     <= 1'b0;
        busy_o      <= 1'b1;
        done_o      <= 1'b0;
        fail_o      <= 1'b0;
        fail_addr_o <= {ADDR_WIDTH{1'b0}};
      end else begin
        state_q <= state_nxt;
        addr_q  <= addr_nxt;
        phase_q <= phase_nxt;
        if (state_q == DONE && busy_o) begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        // Only the first mismatch is recorded; later ones leave the flags untouched.
        if (cmp_vld_q && (q_t_i != cmp_exp_q) && !fail_o) begin
          fail_o      <= 1'b1;
          fail_addr_o <= cmp_addr_q;
        end
      end
      csn_t_o    <= !op_en;
      wen_t_o    <= !(op_en && op_we);
      a_t_o      <= op_en ? addr_q : {ADDR_WIDTH{1'b0}};
      d_t_o      <= op_en ? pattern(addr_q[0], op_inv) : {DATA_WIDTH{1'b0}};
      be_t_o     <= (accept || (busy_o && state_q != DONE)) ? {NUM_BYTE{1'b1}} : {NUM_BYTE{1'b0}};
      // During a read d_t_o carries the expected word, compared when q_t_i arrives.
      cmp_vld_q  <= !csn_t_o && wen_t_o;
      cmp_exp_q  <= d_t_o;
      cmp_addr_q <= a_t_o;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist_ctrl.sv
// Directed bench: two controllers (N=4 and N=8) with behavioural regfile models and fault injection.
module tb_hwpe_ctrl_regfile_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT with ADDR_WIDTH=2 ----------------
  logic        rst2, start2, busy2, done2, fail2, bist2, csn2, wen2;
  logic [1:0]  fail_addr2, a2;
  logic [31:0] d2, q2, wd2;
  logic [3:0]  be2;
  logic        short2;
  logic [31:0] mem2 [4];

  hwpe_ctrl_regfile_bist_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) u_dut2 (
    .clk(clk), .rst(rst2), .start_i(start2),
    .busy_o(busy2), .done_o(done2), .fail_o(fail2), .fail_addr_o(fail_addr2),
    .bist_o(bist2), .csn_t_o(csn2), .wen_t_o(wen2), .a_t_o(a2), .d_t_o(d2),
    .be_t_o(be2), .q_t_i(q2)
  );

  // data-line short between bits 0 and 1 modelled as wired-AND on the write path
  assign wd2 = short2 ? {d2[31:2], {2{d2[1] & d2[0]}}} : d2;

  always @(posedge clk) begin
    if (!csn2) begin
      if (!wen2) begin
        for (int b = 0; b < 4; b++) if (be2[b]) mem2[a2][8*b +: 8] <= wd2[8*b +: 8];
      end else begin
        q2 <= mem2[a2];
      end
    end
  end

  // ---------------- DUT with ADDR_WIDTH=3 ----------------
  logic        rst3, start3, busy3, done3, fail3, bist3, csn3, wen3;
  logic [2:0]  fail_addr3, a3;
  logic [31:0] d3, q3;
  logic [3:0]  be3;
  logic [31:0] mem3 [8];
  logic [31:0] sa1m3 [8];
  logic [31:0] sa0m3 [8];

  hwpe_ctrl_regfile_bist_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) u_dut3 (
    .clk(clk), .rst(rst3), .start_i(start3),
    .busy_o(busy3), .done_o(done3), .fail_o(fail3), .fail_addr_o(fail_addr3),
    .bist_o(bist3), .csn_t_o(csn3), .wen_t_o(wen3), .a_t_o(a3), .d_t_o(d3),
    .be_t_o(be3), .q_t_i(q3)
  );

  always @(posedge clk) begin
    if (!csn3) begin
      if (!wen3) begin
        for (int b = 0; b < 4; b++) if (be3[b]) mem3[a3][8*b +: 8] <= d3[8*b +: 8];
      end else begin
        q3 <= (mem3[a3] | sa1m3[a3]) & ~sa0m3[a3];
      end
    end
  end

  // ---------------- expected March C- sequence for N=4 ----------------
  bit          e_we [40];
  int          e_a  [40];
  logic [31:0] e_d  [40];
  int          e_n;

  function automatic logic [31:0] bp(input int a, input bit inv);
    logic [31:0] p;
`ifdef HWPE_CTRL_BIST_CHECKERBOARD_EN
    p = 32'h5555_5555;
    if (a % 2 == 1) p = ~p;
`else
    p = 32'h0000_0000;
`endif
    if (inv) p = ~p;
    return p;
  endfunction

  task automatic push(input bit we, input int a, input bit inv);
    e_we[e_n] = we;
    e_a[e_n]  = a;
    e_d[e_n]  = bp(a, inv);
    e_n++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full run on the N=4 controller, optionally pulsing start at edge `poke` while busy.
  task automatic run2(input int poke, input bit exp_fail);
    bit seen;
    seen = 1'b0;
    start2 = 1'b1;
    @(posedge clk); @(negedge clk);
    start2 = 1'b0;
    chk("r2_start_busy", 64'(busy2), 64'(1));
    chk("r2_start_done_clr", 64'(done2), 64'(0));
    chk("r2_start_fail_clr", 64'(fail2), 64'(0));
    for (int k = 1; k <= 60 && !seen; k++) begin
      if (k == poke) start2 = 1'b1;
      @(posedge clk); @(negedge clk);
      start2 = 1'b0;
      if (k <= 40) begin
        chk("r2_op_csn", 64'(csn2), 64'(0));
        chk("r2_op_wen", 64'(wen2), 64'(!e_we[k-1]));
        chk("r2_op_addr", 64'(a2), 64'(e_a[k-1]));
        if (e_we[k-1]) chk("r2_op_data", 64'(d2), 64'(e_d[k-1]));
        if (k == 1) chk("r2_be", 64'(be2), 64'(4'hf));
      end
      if (k == 41) begin
        chk("r2_flush_idle", 64'(csn2), 64'(1));
        chk("r2_flush_busy", 64'(busy2), 64'(1));
      end
      if (done2) begin
        seen = 1'b1;
        chk("r2_done_edge", 64'(k), 64'(42));
      end
    end
    chk("r2_done_seen", 64'(seen), 64'(1));
    chk("r2_end_fail", 64'(fail2), 64'(exp_fail));
    chk("r2_end_bist", 64'(bist2), 64'(0));
    chk("r2_end_busy", 64'(busy2), 64'(0));
  endtask

  // Full run on the N=8 controller with the currently injected faults.
  task automatic run3(input int exp_first, input int exp_addr);
    bit seen;
    int first;
    seen  = 1'b0;
    first = -1;
    start3 = 1'b1;
    @(posedge clk); @(negedge clk);
    start3 = 1'b0;
    chk("r3_start_busy", 64'(busy3), 64'(1));
    chk("r3_fail_clr", 64'(fail3), 64'(0));
    chk("r3_addr_clr", 64'(fail_addr3), 64'(0));
    for (int k = 1; k <= 120 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      if (fail3 && first < 0) first = k;
      if (done3) begin
        seen = 1'b1;
        chk("r3_done_edge", 64'(k), 64'(82));
      end
    end
    chk("r3_done_seen", 64'(seen), 64'(1));
    chk("r3_first_fail_edge", 64'(first), 64'(exp_first));
    chk("r3_fail", 64'(fail3), 64'(1));
    chk("r3_fail_addr", 64'(fail_addr3), 64'(exp_addr));
    @(posedge clk); @(negedge clk);
    chk("r3_done_hold", 64'(done3), 64'(1));
    chk("r3_addr_hold", 64'(fail_addr3), 64'(exp_addr));
  endtask

  initial begin
    rst2 = 1'b1; start2 = 1'b0; short2 = 1'b0;
    rst3 = 1'b1; start3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sa1m3[i] = 32'h0;
      sa0m3[i] = 32'h0;
    end
    e_n = 0;
    for (int a = 0; a < 4; a++) push(1'b1, a, 1'b0);
    for (int a = 0; a < 4; a++) begin push(1'b0, a, 1'b0); push(1'b1, a, 1'b1); end
    for (int a = 0; a < 4; a++) begin push(1'b0, a, 1'b1); push(1'b1, a, 1'b0); end
    for (int a = 3; a >= 0; a--) begin push(1'b0, a, 1'b0); push(1'b1, a, 1'b1); end
    for (int a = 3; a >= 0; a--) begin push(1'b0, a, 1'b1); push(1'b1, a, 1'b0); end
    for (int a = 3; a >= 0; a--) push(1'b0, a, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bist", 64'(bist2), 64'(0));
    chk("rst_csn", 64'(csn2), 64'(1));
    chk("rst_wen", 64'(wen2), 64'(1));
    chk("rst_a", 64'(a2), 64'(0));
    chk("rst_d", 64'(d2), 64'(0));
    chk("rst_be", 64'(be2), 64'(0));
    chk("rst_busy", 64'(busy2), 64'(0));
    chk("rst_done", 64'(done2), 64'(0));
    chk("rst_fail", 64'(fail2), 64'(0));
    chk("rst_fail_addr", 64'(fail_addr2), 64'(0));

    // reset wins over a simultaneous start
    start2 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_prio_busy", 64'(busy2), 64'(0));
    chk("rst_prio_csn", 64'(csn2), 64'(1));
    rst2 = 1'b0; start2 = 1'b0; rst3 = 1'b0;
    @(posedge clk); @(negedge clk);

    run2(0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_level", 64'(done2), 64'(1));

    // starts while busy (mid-run, and in DONE before busy drops) are ignored
    run2(5, 1'b0);
    run2(42, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("late_poke_done", 64'(done2), 64'(1));
    chk("late_poke_busy", 64'(busy2), 64'(0));

    // reset during M3
    start2 = 1'b1;
    @(posedge clk); @(negedge clk);
    start2 = 1'b0;
    repeat (23) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk); @(negedge clk);
    rst2 = 1'b0;
    chk("midrst_csn", 64'(csn2), 64'(1));
    chk("midrst_bist", 64'(bist2), 64'(0));
    chk("midrst_busy", 64'(busy2), 64'(0));
    chk("midrst_done", 64'(done2), 64'(0));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_resume", 64'(csn2), 64'(1));
    chk("midrst_no_done", 64'(done2), 64'(0));
    run2(0, 1'b0);

`ifdef HWPE_CTRL_BIST_CHECKERBOARD_EN
    short2 = 1'b1;
    run2(0, 1'b1);
    short2 = 1'b0;
`endif

    // stuck-at-1 bit 0 at address 2
    sa1m3[2] = 32'h1;
`ifdef HWPE_CTRL_BIST_CHECKERBOARD_EN
    run3(31, 2);
`else
    run3(15, 2);
`endif
    // stuck-at-0 at address 6 plus stuck-at-1 at address 1
    sa1m3[2] = 32'h0;
    sa0m3[6] = 32'h1;
    sa1m3[1] = 32'h1;
    run3(13, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
